// File: rtl/led_pkg.sv
// Shared types for the LED keyframe sequencer: FSM states and the keyframe table entry.
package led_pkg;

  localparam int HOLD_W  = 16;
  localparam int COLOR_W = 16;

  typedef enum logic [1:0] {IDLE, RAMP, HOLD} seq_state_t;

  typedef struct packed {
    logic [COLOR_W-1:0] r;
    logic [COLOR_W-1:0] g;
    logic [COLOR_W-1:0] b;
    logic [HOLD_W-1:0]  hold;
  } frame_t;

endpackage

// File: rtl/led_ramp_step.sv
// One channel of the colour ramp: moves the current duty one count toward its target.
module led_ramp_step #(
  parameter int DW = 11
) (
  input  logic [DW-1:0] cur,
  input  logic [DW-1:0] target,
  output logic [DW-1:0] nxt,
  output logic          at_target
);

  always_comb begin
    nxt = cur;
    if (cur < target) begin
      nxt = cur + DW'(1);
    end else if (cur > target) begin
      nxt = cur - DW'(1);
    end
  end

  // Reports whether the stepped value lands on the target, so the caller can leave RAMP on that tick.
  assign at_target = (nxt == target);

endmodule

// File: rtl/led_sequencer.sv
// Keyframe scheduler: ramps the three PWM duty values through a programmable table of RGB frames.
module led_sequencer
  import led_pkg::*;
#(
  parameter  int PWM_INTERVAL = 1200,
  parameter  int NUM_FRAMES   = 8,
  parameter  int STEP_CYCLES  = 12000,
  localparam int DW           = $clog2(PWM_INTERVAL),
  localparam int AW           = $clog2(NUM_FRAMES)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          stop,
  input  logic          loop_en,
  input  logic [AW:0]   frame_count,
  input  logic          cfg_we,
  input  logic [AW-1:0] cfg_addr,
  input  logic [DW-1:0] cfg_r,
  input  logic [DW-1:0] cfg_g,
  input  logic [DW-1:0] cfg_b,
  input  logic [15:0]   cfg_hold,
  output logic [DW-1:0] pwm_value_r,
  output logic [DW-1:0] pwm_value_g,
  output logic [DW-1:0] pwm_value_b,
  output logic          busy,
  output logic [AW-1:0] frame_idx,
  output logic          frame_done
);

  localparam int                SW        = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
  localparam logic [SW-1:0]     STEP_LAST = SW'(STEP_CYCLES - 1);
  localparam logic [DW-1:0]     DUTY_MAX  = DW'(PWM_INTERVAL - 1);
  localparam logic [AW:0]       CNT_MAX   = (AW+1)'(NUM_FRAMES);

  function automatic logic [DW-1:0] clamp_duty(input logic [DW-1:0] v);
    return (v > DUTY_MAX) ? DUTY_MAX : v;
  endfunction

  seq_state_t        state_q, state_d;
  logic [AW-1:0]     idx_q, idx_d;
  logic [AW:0]       count_q, count_d;
  logic [SW-1:0]     step_q, step_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic [DW-1:0]     r_q, g_q, b_q, r_d, g_d, b_d;
  logic [DW-1:0]     r_nx, g_nx, b_nx;
  logic              r_at, g_at, b_at, all_at;
  logic              done_q, done_d;
  logic              tick, count_ok;
  logic [AW:0]       idx_inc;
  frame_t            table_q [NUM_FRAMES];
  frame_t            tgt;
  logic              unused_tgt_hi;

  // The table is plain storage; it keeps its contents across reset.
  always_ff @(posedge clk) begin
    if (cfg_we && state_q == IDLE) begin
      table_q[cfg_addr] <= '{r: COLOR_W'(clamp_duty(cfg_r)),
                             g: COLOR_W'(clamp_duty(cfg_g)),
                             b: COLOR_W'(clamp_duty(cfg_b)),
                             hold: cfg_hold};
    end
  end

  assign tgt           = table_q[idx_q];
  assign unused_tgt_hi = ^{tgt.r[COLOR_W-1:DW], tgt.g[COLOR_W-1:DW], tgt.b[COLOR_W-1:DW]};

  led_ramp_step #(.DW(DW)) u_step_r (.cur(r_q), .target(tgt.r[DW-1:0]), .nxt(r_nx), .at_target(r_at));
  led_ramp_step #(.DW(DW)) u_step_g (.cur(g_q), .target(tgt.g[DW-1:0]), .nxt(g_nx), .at_target(g_at));
  led_ramp_step #(.DW(DW)) u_step_b (.cur(b_q), .target(tgt.b[DW-1:0]), .nxt(b_nx), .at_target(b_at));

  assign all_at   = r_at & g_at & b_at;
  assign tick     = (state_q != IDLE) && (step_q == STEP_LAST);
  assign count_ok = (frame_count != '0) && (frame_count <= CNT_MAX);
  assign idx_inc  = {1'b0, idx_q} + (AW+1)'(1);

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    count_d = count_q;
    step_d  = step_q;
    hold_d  = hold_q;
    r_d     = r_q;
    g_d     = g_q;
    b_d     = b_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start && !stop && count_ok) begin
          count_d = frame_count;
          idx_d   = '0;
          step_d  = '0;
          state_d = RAMP;
        end
      end
      RAMP: begin
        if (stop) begin
          step_d  = '0;
          state_d = IDLE;
        end else begin
          step_d = tick ? '0 : step_q + SW'(1);
          if (tick) begin
            r_d = r_nx;
            g_d = g_nx;
            b_d = b_nx;
            if (all_at) begin
              hold_d  = tgt.hold;
              state_d = HOLD;
            end
          end
        end
      end
      HOLD: begin
        if (stop) begin
          step_d  = '0;
          state_d = IDLE;
        end else begin
          step_d = tick ? '0 : step_q + SW'(1);
          if (tick) begin
            if (hold_q == '0) begin
              done_d = 1'b1;
              if (idx_inc < count_q) begin
                idx_d   = idx_q + AW'(1);
                state_d = RAMP;
              end else if (loop_en) begin
                idx_d   = '0;
                state_d = RAMP;
              end else begin
                state_d = IDLE;
              end
            end else begin
              hold_d = hold_q - HOLD_W'(1);
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      count_q <= '0;
      step_q  <= '0;
      hold_q  <= '0;
      r_q     <= '0;
      g_q     <= '0;
      b_q     <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      count_q <= count_d;
      step_q  <= step_d;
      hold_q  <= hold_d;
      r_q     <= r_d;
      g_q     <= g_d;
      b_q     <= b_d;
      done_q  <= done_d;
    end
  end

  assign pwm_value_r = r_q;
  assign pwm_value_g = g_q;
  assign pwm_value_b = b_q;
  assign busy        = (state_q != IDLE);
  assign frame_idx   = idx_q;
  assign frame_done  = done_q;

endmodule

// File: tb/tb_led_sequencer.sv
// Directed self-checking bench for led_sequencer with a 4-cycle step so ramps stay short.
module tb_led_sequencer;

  localparam int DW = 11;
  localparam int AW = 3;

  logic          clk, rst_n, start, stop, loop_en, cfg_we;
  logic [AW:0]   frame_count;
  logic [AW-1:0] cfg_addr;
  logic [DW-1:0] cfg_r, cfg_g, cfg_b;
  logic [15:0]   cfg_hold;
  logic [DW-1:0] pwm_value_r, pwm_value_g, pwm_value_b;
  logic          busy, frame_done;
  logic [AW-1:0] frame_idx;

  int n_checks = 0;
  int n_fail   = 0;

  led_sequencer #(.PWM_INTERVAL(1200), .NUM_FRAMES(8), .STEP_CYCLES(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .loop_en(loop_en),
    .frame_count(frame_count), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
    .cfg_r(cfg_r), .cfg_g(cfg_g), .cfg_b(cfg_b), .cfg_hold(cfg_hold),
    .pwm_value_r(pwm_value_r), .pwm_value_g(pwm_value_g), .pwm_value_b(pwm_value_b),
    .busy(busy), .frame_idx(frame_idx), .frame_done(frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    cyc(2);
    rst_n = 1'b1;
    cyc(1);
  endtask

  task automatic write_frame(input int a, input int r, input int g, input int b, input int h);
    cfg_addr = a[AW-1:0];
    cfg_r    = r[DW-1:0];
    cfg_g    = g[DW-1:0];
    cfg_b    = b[DW-1:0];
    cfg_hold = h[15:0];
    cfg_we   = 1'b1;
    cyc(1);
    cfg_we   = 1'b0;
  endtask

  task automatic start_seq(input int cnt);
    frame_count = cnt[AW:0];
    start       = 1'b1;
    cyc(1);
    start       = 1'b0;
  endtask

  task automatic test_reset();
    #3;
    n_checks++;
    if (pwm_value_r !== 0 || pwm_value_g !== 0 || pwm_value_b !== 0 || busy !== 1'b0 ||
        frame_idx !== 0 || frame_done !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state: got rgb=(%0d,%0d,%0d) busy=%b idx=%0d done=%b, want all zero",
               pwm_value_r, pwm_value_g, pwm_value_b, busy, frame_idx, frame_done);
    end
    cyc(2);
    rst_n = 1'b1;
    cyc(1);
  endtask

  task automatic test_single_frame();
    int er, eb;
    logic eb_busy, e_done;
    write_frame(0, 100, 0, 50, 2);
    loop_en = 1'b0;
    start_seq(1);
    n_checks++;
    if (busy !== 1'b1) begin
      n_fail++;
      $display("FAIL busy_rise: got %b want 1", busy);
    end
    for (int c = 1; c <= 416; c++) begin
      cyc(1);
      er      = (c / 4 > 100) ? 100 : c / 4;
      eb      = (c / 4 > 50) ? 50 : c / 4;
      eb_busy = (c < 412);
      e_done  = (c == 412);
      n_checks++;
      if (pwm_value_r !== er || pwm_value_g !== 0 || pwm_value_b !== eb ||
          busy !== eb_busy || frame_done !== e_done) begin
        n_fail++;
        $display("FAIL single_frame c=%0d: got rgb=(%0d,%0d,%0d) busy=%b done=%b want (%0d,0,%0d) busy=%b done=%b",
                 c, pwm_value_r, pwm_value_g, pwm_value_b, busy, frame_done, er, eb, eb_busy, e_done);
      end
    end
  endtask

  task automatic test_loop();
    int pr, pg, pb, dr, dg, db, eidx;
    logic ok, e_done;
    do_reset();
    write_frame(0, 10, 10, 10, 0);
    write_frame(1, 0, 20, 10, 0);
    loop_en = 1'b1;
    start_seq(2);
    pr = 0; pg = 0; pb = 0;
    for (int c = 1; c <= 180; c++) begin
      cyc(1);
      dr = int'(pwm_value_r) - pr;
      dg = int'(pwm_value_g) - pg;
      db = int'(pwm_value_b) - pb;
      ok = (dr >= -1 && dr <= 1 && dg >= -1 && dg <= 1 && db >= -1 && db <= 1);
      if (c % 4 != 0) ok = ok && dr == 0 && dg == 0 && db == 0;
      eidx   = (c / 44) % 2;
      e_done = (c % 44 == 0);
      n_checks++;
      if (!ok || frame_idx !== eidx || frame_done !== e_done || busy !== 1'b1) begin
        n_fail++;
        $display("FAIL loop c=%0d: got delta=(%0d,%0d,%0d) idx=%0d done=%b busy=%b want idx=%0d done=%b busy=1",
                 c, dr, dg, db, frame_idx, frame_done, busy, eidx, e_done);
      end
      if (c == 40 || c == 128) begin
        n_checks++;
        if (pwm_value_r !== 10 || pwm_value_g !== 10 || pwm_value_b !== 10) begin
          n_fail++;
          $display("FAIL loop_frame0 c=%0d: got (%0d,%0d,%0d) want (10,10,10)",
                   c, pwm_value_r, pwm_value_g, pwm_value_b);
        end
      end
      if (c == 84 || c == 172) begin
        n_checks++;
        if (pwm_value_r !== 0 || pwm_value_g !== 20 || pwm_value_b !== 10) begin
          n_fail++;
          $display("FAIL loop_frame1 c=%0d: got (%0d,%0d,%0d) want (0,20,10)",
                   c, pwm_value_r, pwm_value_g, pwm_value_b);
        end
      end
      pr = int'(pwm_value_r); pg = int'(pwm_value_g); pb = int'(pwm_value_b);
    end
    stop = 1'b1;
    cyc(1);
    stop = 1'b0;
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL loop_stop: busy got %b want 0", busy);
    end
    loop_en = 1'b0;
  endtask

  task automatic test_clamp();
    int max_r, done_c;
    do_reset();
    write_frame(0, 2000, 0, 0, 0);
    start_seq(1);
    max_r = 0; done_c = -1;
    for (int c = 1; c <= 4805; c++) begin
      cyc(1);
      if (int'(pwm_value_r) > max_r) max_r = int'(pwm_value_r);
      if (frame_done === 1'b1) done_c = c;
    end
    n_checks++;
    if (max_r !== 1199 || pwm_value_r !== 1199) begin
      n_fail++;
      $display("FAIL clamp_value: got max=%0d final=%0d want 1199", max_r, pwm_value_r);
    end
    n_checks++;
    if (done_c !== 4800 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL clamp_timing: got done at %0d busy=%b want 4800 busy=0", done_c, busy);
    end
  endtask

  task automatic test_stop();
    do_reset();
    write_frame(0, 100, 0, 0, 0);
    start_seq(1);
    cyc(148);
    n_checks++;
    if (pwm_value_r !== 37) begin
      n_fail++;
      $display("FAIL stop_pre: r got %0d want 37", pwm_value_r);
    end
    stop = 1'b1;
    cyc(1);
    stop = 1'b0;
    for (int c = 0; c < 12; c++) begin
      n_checks++;
      if (busy !== 1'b0 || pwm_value_r !== 37 || frame_done !== 1'b0) begin
        n_fail++;
        $display("FAIL stop_freeze c=%0d: got busy=%b r=%0d done=%b want 0 37 0",
                 c, busy, pwm_value_r, frame_done);
      end
      cyc(1);
    end
    start_seq(1);
    cyc(4);
    n_checks++;
    if (pwm_value_r !== 38 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL stop_resume: got r=%0d busy=%b want 38 1", pwm_value_r, busy);
    end
    cyc(4);
    n_checks++;
    if (pwm_value_r !== 39) begin
      n_fail++;
      $display("FAIL stop_resume2: r got %0d want 39", pwm_value_r);
    end
    stop = 1'b1;
    cyc(1);
    stop = 1'b0;
  endtask

  task automatic test_ignored();
    do_reset();
    write_frame(0, 5, 5, 5, 0);
    frame_count = 1;
    start = 1'b1;
    stop  = 1'b1;
    cyc(1);
    start = 1'b0;
    stop  = 1'b0;
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL start_stop_same: busy got %b want 0", busy);
    end
    start_seq(0);
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL count_zero: busy got %b want 0", busy);
    end
    start_seq(9);
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL count_over: busy got %b want 0", busy);
    end
    start_seq(8);
    n_checks++;
    if (busy !== 1'b1) begin
      n_fail++;
      $display("FAIL count_max: busy got %b want 1", busy);
    end
    stop = 1'b1;
    cyc(1);
    stop = 1'b0;
    start_seq(1);
    cyc(1);
    write_frame(0, 50, 50, 50, 0);
    cyc(23);
    n_checks++;
    if (busy !== 1'b0 || pwm_value_r !== 5 || pwm_value_g !== 5 || pwm_value_b !== 5) begin
      n_fail++;
      $display("FAIL busy_write_run1: got busy=%b rgb=(%0d,%0d,%0d) want 0 (5,5,5)",
               busy, pwm_value_r, pwm_value_g, pwm_value_b);
    end
    start_seq(1);
    cyc(7);
    n_checks++;
    if (busy !== 1'b1 || frame_done !== 1'b0) begin
      n_fail++;
      $display("FAIL busy_write_hold: got busy=%b done=%b want 1 0", busy, frame_done);
    end
    cyc(1);
    n_checks++;
    if (busy !== 1'b0 || frame_done !== 1'b1 || pwm_value_r !== 5) begin
      n_fail++;
      $display("FAIL busy_write_run2: got busy=%b done=%b r=%0d want 0 1 5", busy, frame_done, pwm_value_r);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    write_frame(0, 3, 0, 0, 5);
    start_seq(1);
    cyc(14);
    n_checks++;
    if (busy !== 1'b1 || pwm_value_r !== 3) begin
      n_fail++;
      $display("FAIL hold_entry: got busy=%b r=%0d want 1 3", busy, pwm_value_r);
    end
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (pwm_value_r !== 0 || pwm_value_g !== 0 || pwm_value_b !== 0 || busy !== 1'b0 ||
        frame_idx !== 0 || frame_done !== 1'b0) begin
      n_fail++;
      $display("FAIL async_reset: got rgb=(%0d,%0d,%0d) busy=%b idx=%0d done=%b want all zero",
               pwm_value_r, pwm_value_g, pwm_value_b, busy, frame_idx, frame_done);
    end
    #2;
    rst_n = 1'b1;
    cyc(1);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; stop = 1'b0; loop_en = 1'b0; cfg_we = 1'b0;
    frame_count = '0; cfg_addr = '0; cfg_r = '0; cfg_g = '0; cfg_b = '0; cfg_hold = '0;
    test_reset();
    test_single_frame();
    test_loop();
    test_clamp();
    test_stop();
    test_ignored();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
